router_fifo_param: RTL and testbench
====================================

Name: router_fifo_param

Overview:
- Parametrised successor to the router's per-destination output FIFO. Generalised in data width and depth.
- Each entry carries a header tag captured from lfd_state.
- Adds over the fixed 8x16 FIFO: registered read data with a valid strobe, fill count, almost-full/almost-empty watermarks, packet-length tracking on the read side, and sticky overflow/underflow error flags.
- Sits between the router register block (write side) and the destination read port (read side), one instance per destination.

Parameters:
- WIDTH, 8: data width in bits; must be >= 4.
- DEPTH, 16: number of entries; power of two, >= 4.
- AF_MARGIN, 2: almost_full asserts when fill_count >= DEPTH-AF_MARGIN.
- AE_MARGIN, 1: almost_empty asserts when fill_count <= AE_MARGIN.

Ports:
- clock  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- soft_reset  in  1  synchronous flush, active high.
- write_enb  in  1  write request.
- read_enb  in  1  read request.
- lfd_state  in  1  marks data_in as a packet header byte.
- data_in  in  WIDTH  write data.
- data_out  out  WIDTH  registered read data.
- data_out_valid  out  1  data_out updated this cycle (one pulse per accepted read).
- hdr_out  out  1  tag bit of the entry currently on data_out.
- full  out  1  fill_count == DEPTH.
- empty  out  1  fill_count == 0.
- almost_full  out  1  watermark, see AF_MARGIN.
- almost_empty  out  1  watermark, see AE_MARGIN.
- fill_count  out  $clog2(DEPTH+1)  current occupancy.
- pkt_active  out  1  a read-side packet is in progress (pkt_cnt != 0).
- overflow_err  out  1  sticky; set by write_enb while full.
- underflow_err  out  1  sticky; set by read_enb while empty.

Behaviour:
- Storage: DEPTH x (WIDTH+1) entries; bit WIDTH holds the lfd tag.
- Write and read pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Write accept: wa = write_enb & ~full. On accept, mem[wr_ptr] <= {lfd_state, data_in} and wr_ptr increments.
- Read accept: ra = read_enb & ~empty. On accept, data_out/hdr_out <= mem[rd_ptr] at the next edge (1-cycle latency), data_out_valid pulses high for that one cycle, and rd_ptr increments.
  - Without an accepted read, data_out and hdr_out hold their values and data_out_valid is 0.
- fill_count: +1 on wa only, -1 on ra only, unchanged on both or neither.
  - When full, a simultaneous read and write performs the read only; the write is rejected and counts as overflow.
  - When empty, a simultaneous read and write performs the write only and flags underflow.
- full, empty, almost_full and almost_empty are combinational decodes of the registered fill_count.
- Packet counter pkt_cnt, width WIDTH-2:
  - On ra of a tagged entry: pkt_cnt <= entry[WIDTH-1:2] + 1 (payload length plus parity byte).
  - On ra of an untagged entry while pkt_cnt != 0: pkt_cnt decrements.
  - A tagged entry read while pkt_cnt != 0 reloads pkt_cnt (new packet; the old packet is truncated).
  - The +1 is computed at WIDTH-1 bits, then saturates to all-ones if it overflows.
- pkt_active = (pkt_cnt != 0).
- overflow_err is set when write_enb & full; underflow_err is set when read_enb & empty. Both are cleared only by resetn or soft_reset.
- soft_reset:
  - At the next edge: pointers, fill_count, pkt_cnt, data_out, hdr_out, data_out_valid and both error flags go to 0.
  - Takes priority over any write or read in the same cycle.
  - Memory contents are not cleared.
- resetn low, at any time (including mid-packet): same state as soft_reset, applied asynchronously.
  - Output values in reset: data_out=0, hdr_out=0, data_out_valid=0, fill_count=0, empty=1, full=0, almost_empty=1, almost_full=0, pkt_active=0, overflow_err=0, underflow_err=0.
- Outputs never go high-impedance.

Test Plan:
- Reset and default params: write header 8'h0D (lfd=1), then 4 bytes 8'h11..8'h14 → fill_count=5. Read 5 times → data_out sequence 0D,11,12,13,14 one cycle after each read; hdr_out=1 only with 0D; pkt_cnt=4 after header, pkt_active drops after 8'h14; empty=1.
- Fill to full: write 17 bytes back-to-back → full=1 after the 16th; 17th rejected; overflow_err=1; almost_full=1 from fill_count=14. Drain 16 → the first 16 values return in order and wrap is correct.
- Simultaneous read+write at fill_count=8 for 20 cycles → fill_count stays 8; data order preserved across pointer wrap.
- Read on empty: read_enb=1 with empty=1 → data_out_valid=0, data_out unchanged, underflow_err=1. Assert soft_reset one cycle → underflow_err=0.
- Mid-packet resets: after header 8'h0D plus 2 bytes read, assert soft_reset together with write_enb → pkt_active=0, fill_count=0, write ignored. Repeat using resetn asserted mid-cycle → outputs clear immediately.
- Parameter sweep WIDTH=16, DEPTH=4, AF_MARGIN=1: write header 16'h0010 → pkt_cnt=5 on read; full after 4 writes; almost_full at fill_count=3.

Source files
------------

// File: rtl/router_fifo_param.sv
// Parametrised per-destination output FIFO: tagged entries, registered read data,
// occupancy watermarks, read-side packet-length tracking and sticky error flags.
module router_fifo_param #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_MARGIN = 2,
    parameter int unsigned AE_MARGIN = 1
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           soft_reset,
    input  logic                           write_enb,
    input  logic                           read_enb,
    input  logic                           lfd_state,
    input  logic [WIDTH-1:0]               data_in,
    output logic [WIDTH-1:0]               data_out,
    output logic                           data_out_valid,
    output logic                           hdr_out,
    output logic                           full,
    output logic                           empty,
    output logic                           almost_full,
    output logic                           almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]     fill_count,
    output logic                           pkt_active,
    output logic                           overflow_err,
    output logic                           underflow_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PKT_W = WIDTH - 2;
    localparam int unsigned ENT_W = WIDTH + 1;

    if (WIDTH < 4 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
        $error("router_fifo_param: WIDTH must be >= 4 and DEPTH a power of two >= 4");
    end

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PKT_W-1:0] pkt_cnt;
    logic [ENT_W-1:0] rd_entry;
    logic             wr_acc;
    logic             rd_acc;
    logic [PKT_W:0]   pkt_inc;
    logic [PKT_W-1:0] pkt_load;

    // Status flags decode straight off the registered occupancy.
    assign full         = (fill_count == CNT_W'(DEPTH));
    assign empty        = (fill_count == CNT_W'(0));
    assign almost_full  = (fill_count >= CNT_W'(DEPTH - AF_MARGIN));
    assign almost_empty = (fill_count <= CNT_W'(AE_MARGIN));
    assign pkt_active   = (pkt_cnt != PKT_W'(0));

    assign wr_acc   = write_enb & ~full;
    assign rd_acc   = read_enb & ~empty;
    assign rd_entry = mem[rd_ptr];

    // Header length field plus the parity byte, saturating at all-ones.
    always_comb begin
        pkt_inc  = {1'b0, rd_entry[WIDTH-1:2]} + (PKT_W+1)'(1);
        pkt_load = pkt_inc[PKT_W] ? {PKT_W{1'b1}} : pkt_inc[PKT_W-1:0];
    end

    // Storage is deliberately left out of both resets.
    always_ff @(posedge clock) begin
        if (wr_acc && !soft_reset) begin
            mem[wr_ptr] <= {lfd_state, data_in};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_count <= '0;
        end else if (soft_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_count <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   fill_count <= fill_count + CNT_W'(1);
                2'b01:   fill_count <= fill_count - CNT_W'(1);
                default: fill_count <= fill_count;
            endcase
        end
    end

    // Registered read port: one-cycle latency, valid strobe per accepted read.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            data_out       <= '0;
            hdr_out        <= 1'b0;
            data_out_valid <= 1'b0;
        end else if (soft_reset) begin
            data_out       <= '0;
            hdr_out        <= 1'b0;
            data_out_valid <= 1'b0;
        end else begin
            data_out_valid <= rd_acc;
            if (rd_acc) begin
                data_out <= rd_entry[WIDTH-1:0];
                hdr_out  <= rd_entry[WIDTH];
            end
        end
    end

    // A tagged read always reloads, truncating any packet still in flight.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pkt_cnt <= '0;
        end else if (soft_reset) begin
            pkt_cnt <= '0;
        end else if (rd_acc) begin
            if (rd_entry[WIDTH]) begin
                pkt_cnt <= pkt_load;
            end else if (pkt_cnt != PKT_W'(0)) begin
                pkt_cnt <= pkt_cnt - PKT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else if (soft_reset) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (write_enb && full) begin
                overflow_err <= 1'b1;
            end
            if (read_enb && empty) begin
                underflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_router_fifo_param.sv
// Randomised scoreboard bench for router_fifo_param against a queue-based reference,
// plus a small directed run on a WIDTH=16, DEPTH=4 instance.
module tb_router_fifo_param;

    localparam int unsigned D = 16;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       resetn, soft_reset, write_enb, read_enb, lfd_state;
    logic [7:0] data_in, data_out;
    logic       data_out_valid, hdr_out, full, empty, almost_full, almost_empty;
    logic [4:0] fill_count;
    logic       pkt_active, overflow_err, underflow_err;

    router_fifo_param dut (
        .clock(clock), .resetn(resetn), .soft_reset(soft_reset),
        .write_enb(write_enb), .read_enb(read_enb), .lfd_state(lfd_state),
        .data_in(data_in), .data_out(data_out), .data_out_valid(data_out_valid),
        .hdr_out(hdr_out), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .fill_count(fill_count), .pkt_active(pkt_active),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    logic        p_sr, p_we, p_re, p_lfd;
    logic [15:0] p_din, p_dout;
    logic        p_valid, p_hdr, p_full, p_empty, p_af, p_ae;
    logic [2:0]  p_fill;
    logic        p_pkt, p_ovf, p_unf;

    router_fifo_param #(.WIDTH(16), .DEPTH(4), .AF_MARGIN(1), .AE_MARGIN(1)) dut16 (
        .clock(clock), .resetn(resetn), .soft_reset(p_sr),
        .write_enb(p_we), .read_enb(p_re), .lfd_state(p_lfd),
        .data_in(p_din), .data_out(p_dout), .data_out_valid(p_valid),
        .hdr_out(p_hdr), .full(p_full), .empty(p_empty), .almost_full(p_af),
        .almost_empty(p_ae), .fill_count(p_fill), .pkt_active(p_pkt),
        .overflow_err(p_ovf), .underflow_err(p_unf)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic       hdr;
        logic [7:0] data;
    } ent_t;

    ent_t mq[$];
    ent_t exp_q[$];
    int   m_pkt;
    bit   m_ovf, m_unf, m_valid;
    ent_t m_last;

    task automatic model_reset();
        mq.delete();
        m_pkt   = 0;
        m_ovf   = 0;
        m_unf   = 0;
        m_valid = 0;
        m_last  = '0;
    endtask

    task automatic check_status();
        int n;
        n = mq.size();
        check("fill_count", fill_count, n);
        check("full", full, n == D);
        check("empty", empty, n == 0);
        check("almost_full", almost_full, n >= D - 2);
        check("almost_empty", almost_empty, n <= 1);
        check("pkt_active", pkt_active, m_pkt != 0);
        check("overflow_err", overflow_err, m_ovf);
        check("underflow_err", underflow_err, m_unf);
        check("data_out_valid", data_out_valid, m_valid);
        check("data_out_hold", data_out, m_last.data);
        check("hdr_out_hold", hdr_out, m_last.hdr);
    endtask

    // Drive one cycle of stimulus, advance the reference, then check status after the edge.
    task automatic step(input bit we, input bit re, input bit lfd, input logic [7:0] din,
                        input bit sr);
        bit   mfull, mempty;
        int   v;
        ent_t e;
        @(negedge clock);
        write_enb  = we;
        read_enb   = re;
        lfd_state  = lfd;
        data_in    = din;
        soft_reset = sr;
        if (sr) begin
            model_reset();
        end else begin
            mfull  = (mq.size() == D);
            mempty = (mq.size() == 0);
            if (we && mfull) m_ovf = 1;
            if (re && mempty) m_unf = 1;
            m_valid = re && !mempty;
            if (m_valid) begin
                e = mq.pop_front();
                exp_q.push_back(e);
                m_last = e;
                if (e.hdr) begin
                    v = int'(e.data) / 4 + 1;
                    m_pkt = (v > 63) ? 63 : v;
                end else if (m_pkt > 0) begin
                    m_pkt--;
                end
            end
            if (we && !mfull) begin
                e.hdr  = lfd;
                e.data = din;
                mq.push_back(e);
            end
        end
        @(posedge clock);
        #1;
        check_status();
    endtask

    task automatic async_reset();
        @(negedge clock);
        write_enb  = 0;
        read_enb   = 0;
        soft_reset = 0;
        #2 resetn = 0;
        #1;
        model_reset();
        check_status();
        @(negedge clock);
        #2 resetn = 1;
    endtask

    // Read-data monitor: every valid pulse must match the oldest outstanding expectation.
    initial begin
        ent_t e;
        forever begin
            @(negedge clock);
            if (resetn === 1'b1 && data_out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", data_out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", data_out, e.data);
                    check("rd_hdr", hdr_out, e.hdr);
                end
            end
        end
    end

    task automatic p_step(input bit we, input bit re, input bit lfd, input logic [15:0] din);
        @(negedge clock);
        p_we  = we;
        p_re  = re;
        p_lfd = lfd;
        p_din = din;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int wp, rp;
        resetn = 0; soft_reset = 0; write_enb = 0; read_enb = 0; lfd_state = 0; data_in = 0;
        p_sr = 0; p_we = 0; p_re = 0; p_lfd = 0; p_din = 0;
        model_reset();
        #12;
        check_status();
        @(negedge clock);
        resetn = 1;

        // Header plus four payload bytes, then drain.
        step(1, 0, 1, 8'h0D, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 8'(8'h11 + i), 0);
        check("t1_fill", fill_count, 5);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 8'h00, 0);
            if (i == 0) check("t1_pkt_after_hdr", pkt_active, 1);
        end
        check("t1_pkt_done", pkt_active, 0);
        check("t1_empty", empty, 1);

        // Fill past full, then drain across the wrap.
        for (int i = 0; i < 17; i++) step(1, 0, 0, 8'($urandom), 0);
        check("t2_full", full, 1);
        check("t2_ovf", overflow_err, 1);
        for (int i = 0; i < 16; i++) step(0, 1, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 1);

        // Steady-state read+write at half occupancy.
        for (int i = 0; i < 8; i++) step(1, 0, 0, 8'($urandom), 0);
        for (int i = 0; i < 20; i++) step(1, 1, 0, 8'($urandom), 0);
        check("t3_fill", fill_count, 8);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 8'h00, 0);

        // Read on empty, then soft-reset clears the sticky flag.
        step(0, 1, 0, 8'h00, 0);
        check("t4_unf", underflow_err, 1);
        check("t4_no_valid", data_out_valid, 0);
        step(0, 0, 0, 8'h00, 1);
        check("t4_unf_clr", underflow_err, 0);

        // Soft reset mid-packet with a concurrent write.
        step(1, 0, 1, 8'h0D, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 8'(8'h21 + i), 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00, 0);
        step(1, 0, 0, 8'hAA, 1);
        check("t5_fill", fill_count, 0);
        check("t5_pkt", pkt_active, 0);

        // Same again with an asynchronous reset between edges.
        step(1, 0, 1, 8'h0D, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 8'(8'h31 + i), 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00, 0);
        async_reset();
        check("t5_async_pkt", pkt_active, 0);

        // Length-field saturation header.
        step(1, 0, 1, 8'hFF, 0);
        step(0, 1, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 1);

        // Randomised phases with varying write/read pressure.
        for (int ph = 0; ph < 3; ph++) begin
            wp = 70 - 20 * ph;
            rp = 30 + 20 * ph;
            for (int i = 0; i < 500; i++) begin
                step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
                     $urandom_range(0, 7) == 0, 8'($urandom), $urandom_range(0, 149) == 0);
            end
        end
        step(0, 0, 0, 8'h00, 1);

        // WIDTH=16, DEPTH=4, AF_MARGIN=1 instance.
        p_step(1, 0, 1, 16'h0010);
        check("p_fill1", p_fill, 1);
        p_step(1, 0, 0, 16'hA001);
        check("p_af_at2", p_af, 0);
        p_step(1, 0, 0, 16'hA002);
        check("p_af_at3", p_af, 1);
        check("p_full_at3", p_full, 0);
        p_step(1, 0, 0, 16'hA003);
        check("p_full_at4", p_full, 1);
        p_step(0, 1, 0, 16'h0000);
        check("p_hdr_data", p_dout, 16'h0010);
        check("p_hdr_tag", p_hdr, 1);
        check("p_hdr_valid", p_valid, 1);
        check("p_pkt_start", p_pkt, 1);
        for (int i = 0; i < 3; i++) begin
            p_step(0, 1, 0, 16'h0000);
            check("p_payload", p_dout, 32'hA001 + i);
        end
        p_step(1, 0, 0, 16'hB001);
        p_step(1, 0, 0, 16'hB002);
        p_step(0, 1, 0, 16'h0000);
        check("p_pkt_len4", p_pkt, 1);
        p_step(0, 1, 0, 16'h0000);
        check("p_pkt_len5", p_pkt, 0);
        check("p_empty", p_empty, 1);
        p_step(0, 0, 0, 16'h0000);
        check("p_valid_drop", p_valid, 0);

        @(negedge clock);
        @(negedge clock);
        check("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
